// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - AHB-to-APB bridge encodings, address map and error-FSM state type
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] REG0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REG0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REG1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REG1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REG2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REG2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] SELX_NONE = 3'b000;
  localparam logic [2:0] SELX_0    = 3'b001;
  localparam logic [2:0] SELX_1    = 3'b010;
  localparam logic [2:0] SELX_2    = 3'b100;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR_1    = 2'b01,
    ERR_2    = 2'b10
  } err_state_e;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// rtl/ahb_slave_if_if.sv - AHB slave-side bus bundle with master/slave modports
interface ahb_slave_if_if;

  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        valid;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic        Hwrite_reg;
  logic [2:0]  temp_selx;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hready_err;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg,
    output temp_selx, Hrdata, Hresp, Hready_err
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg,
    input  temp_selx, Hrdata, Hresp, Hready_err
  );

endinterface

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational address to one-hot peripheral select plus mapped flag
module ahb_addr_decode
  import ahb_apb_pkg::*;
(
  input  logic [31:0] i_addr,
  output logic [2:0]  o_selx,
  output logic        o_mapped
);

  always_comb begin
    o_selx = SELX_NONE;
    if (i_addr >= REG0_BASE && i_addr <= REG0_LIMIT) begin
      o_selx = SELX_0;
    end else if (i_addr >= REG1_BASE && i_addr <= REG1_LIMIT) begin
      o_selx = SELX_1;
    end else if (i_addr >= REG2_BASE && i_addr <= REG2_LIMIT) begin
      o_selx = SELX_2;
    end
  end

  assign o_mapped = (o_selx != SELX_NONE);

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end: address/data pipeline, select decode, optional error response
// Define AHB_ERR_RESP_EN to build the two-cycle ERROR response for unmapped transfers.
module ahb_slave_if
  import ahb_apb_pkg::*;
(
  input  logic           Hclk,
  input  logic           Hreset,
  ahb_slave_if_if.slave  bus
);

  logic [31:0] r_haddr1;
  logic [31:0] r_haddr2;
  logic [31:0] r_hwdata1;
  logic [31:0] r_hwdata2;
  logic        r_hwrite;

  logic [2:0]  w_sel_now;
  logic        w_mapped_now;
  logic [2:0]  w_sel1;
  logic        w_mapped1;
  logic        w_active;
  logic [1:0]  w_hresp;
  logic        w_hready_err;

  ahb_addr_decode u_dec_now (
    .i_addr   (bus.Haddr),
    .o_selx   (w_sel_now),
    .o_mapped (w_mapped_now)
  );

  ahb_addr_decode u_dec_stage1 (
    .i_addr   (r_haddr1),
    .o_selx   (w_sel1),
    .o_mapped (w_mapped1)
  );

  assign w_active = bus.Hreadyin & is_active(bus.Htrans);

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_haddr1  <= '0;
      r_haddr2  <= '0;
      r_hwdata1 <= '0;
      r_hwdata2 <= '0;
      r_hwrite  <= 1'b0;
    end else if (bus.Hreadyin) begin
      r_haddr1  <= bus.Haddr;
      r_haddr2  <= r_haddr1;
      r_hwdata1 <= bus.Hwdata;
      r_hwdata2 <= r_hwdata1;
      r_hwrite  <= bus.Hwrite;
    end
  end

`ifdef AHB_ERR_RESP_EN
  err_state_e r_err_state;
  err_state_e w_err_next;
  logic       w_err_req;

  assign w_err_req = w_active & ~w_mapped_now;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_err_state <= ERR_IDLE;
    end else begin
      r_err_state <= w_err_next;
    end
  end

  // ERR_1 is the stalling cycle and always completes into ERR_2.
  always_comb begin
    w_err_next = r_err_state;
    case (r_err_state)
      ERR_IDLE: if (w_err_req) w_err_next = ERR_1;
      ERR_1:    w_err_next = ERR_2;
      ERR_2:    w_err_next = w_err_req ? ERR_1 : ERR_IDLE;
      default:  w_err_next = ERR_IDLE;
    endcase
  end

  always_comb begin
    w_hresp      = HRESP_OKAY;
    w_hready_err = 1'b1;
    case (r_err_state)
      ERR_1: begin
        w_hresp      = HRESP_ERROR;
        w_hready_err = 1'b0;
      end
      ERR_2: begin
        w_hresp      = HRESP_ERROR;
        w_hready_err = 1'b1;
      end
      default: begin
        w_hresp      = HRESP_OKAY;
        w_hready_err = 1'b1;
      end
    endcase
  end
`else
  assign w_hresp      = HRESP_OKAY;
  assign w_hready_err = 1'b1;
`endif

  // The select term guards against a decoder whose flag and code disagree.
  assign bus.valid      = w_active & w_mapped_now & (w_sel_now != SELX_NONE);
  assign bus.temp_selx  = w_mapped1 ? w_sel1 : SELX_NONE;
  assign bus.Haddr1     = r_haddr1;
  assign bus.Haddr2     = r_haddr2;
  assign bus.Hwdata1    = r_hwdata1;
  assign bus.Hwdata2    = r_hwdata2;
  assign bus.Hwrite_reg = r_hwrite;
  assign bus.Hrdata     = bus.Prdata;
  assign bus.Hresp      = w_hresp;
  assign bus.Hready_err = w_hready_err;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - directed self-checking bench for ahb_slave_if with history-based model
module tb_ahb_slave_if;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  ahb_slave_if_if bus ();

  ahb_slave_if dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus.slave)
  );

`ifdef AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] region(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
    if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
    if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
    return 3'b000;
  endfunction

  // Model: every Hreadyin-high edge records the bus inputs; stage N is N samples back.
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } smp_t;

  smp_t hist[$];
  int   err_left = 0;
  int   m_nxt;

  function automatic smp_t stage(input int back);
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return '0;
  endfunction

  always @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      hist.delete();
      err_left = 0;
    end else begin
      m_nxt = 0;
      if (err_left == 2) m_nxt = 1;
      else if (ERR_EN && bus.Hreadyin && bus.Htrans[1] && region(bus.Haddr) == 3'b000) m_nxt = 2;
      err_left = m_nxt;
      if (bus.Hreadyin) hist.push_back({bus.Hwrite, bus.Haddr, bus.Hwdata});
    end
  end

  always @(negedge Hclk) begin
    check("valid",      {31'b0, bus.valid},
          {31'b0, bus.Hreadyin && bus.Htrans[1] && region(bus.Haddr) != 3'b000});
    check("Haddr1",     bus.Haddr1,  stage(0).a);
    check("Haddr2",     bus.Haddr2,  stage(1).a);
    check("Hwdata1",    bus.Hwdata1, stage(0).d);
    check("Hwdata2",    bus.Hwdata2, stage(1).d);
    check("Hwrite_reg", {31'b0, bus.Hwrite_reg}, {31'b0, stage(0).w});
    check("temp_selx",  {29'b0, bus.temp_selx},  {29'b0, region(stage(0).a)});
    check("Hrdata",     bus.Hrdata, bus.Prdata);
    check("Hresp",      {30'b0, bus.Hresp}, (err_left > 0) ? 32'd1 : 32'd0);
    check("Hready_err", {31'b0, bus.Hready_err}, (err_left == 2) ? 32'd0 : 32'd1);
  end

  task automatic drive(input logic rdy, input logic [1:0] tr, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    bus.Hreadyin = rdy;
    bus.Htrans   = tr;
    bus.Hwrite   = w;
    bus.Haddr    = a;
    bus.Hwdata   = d;
  endtask

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    Hreset = 1'b1;
    bus.Prdata = 32'h0;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    #12;
    check("rst_Haddr1", bus.Haddr1, 32'h0);
    check("rst_Hwdata2", bus.Hwdata2, 32'h0);
    check("rst_Hresp", {30'b0, bus.Hresp}, 32'h0);
    check("rst_Hready_err", {31'b0, bus.Hready_err}, 32'h1);
    Hreset = 1'b0;
    tick;

    // single write NONSEQ
    drive(1'b1, 2'b10, 1'b1, 32'h8000_0010, 32'h0);
    #1 check("w_valid", {31'b0, bus.valid}, 32'h1);
    tick;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF);
    check("w_Haddr1", bus.Haddr1, 32'h8000_0010);
    check("w_selx", {29'b0, bus.temp_selx}, 32'h1);
    check("w_Hwrite_reg", {31'b0, bus.Hwrite_reg}, 32'h1);
    tick;
    check("w_Hwdata1", bus.Hwdata1, 32'hDEAD_BEEF);
    check("w_Haddr2", bus.Haddr2, 32'h8000_0010);

    // burst with mid-burst stall
    drive(1'b1, 2'b10, 1'b1, 32'h8400_0000, 32'h0);
    tick;
    drive(1'b1, 2'b11, 1'b1, 32'h8400_0004, 32'h1111_1111);
    tick;
    check("b_Haddr2", bus.Haddr2, 32'h8400_0000);
    check("b_Haddr1", bus.Haddr1, 32'h8400_0004);
    check("b_selx", {29'b0, bus.temp_selx}, 32'h2);
    drive(1'b0, 2'b11, 1'b1, 32'h8400_0008, 32'h2222_2222);
    #1 check("stall_valid", {31'b0, bus.valid}, 32'h0);
    for (int i = 0; i < 3; i++) tick;
    check("stall_Haddr1", bus.Haddr1, 32'h8400_0004);
    check("stall_Haddr2", bus.Haddr2, 32'h8400_0000);
    check("stall_Hwdata1", bus.Hwdata1, 32'h1111_1111);
    drive(1'b1, 2'b11, 1'b1, 32'h8400_0008, 32'h2222_2222);
    tick;
    check("resume_Haddr1", bus.Haddr1, 32'h8400_0008);
    check("resume_Haddr2", bus.Haddr2, 32'h8400_0004);
    check("resume_Hwdata2", bus.Hwdata2, 32'h1111_1111);

    // read of region 2, then BUSY
    drive(1'b1, 2'b10, 1'b0, 32'h8800_0020, 32'h3333_3333);
    bus.Prdata = 32'h1234_5678;
    #1 check("r_Hrdata", bus.Hrdata, 32'h1234_5678);
    tick;
    check("r_selx", {29'b0, bus.temp_selx}, 32'h4);
    check("r_Hwrite_reg", {31'b0, bus.Hwrite_reg}, 32'h0);
    drive(1'b1, 2'b01, 1'b0, 32'h8800_0020, 32'h0);
    #1 check("busy_valid", {31'b0, bus.valid}, 32'h0);
    tick;

    // map boundaries
    drive(1'b1, 2'b10, 1'b0, 32'h8BFF_FFFC, 32'h0);
    #1 check("edge_hi_valid", {31'b0, bus.valid}, 32'h1);
    drive(1'b1, 2'b00, 1'b0, 32'h7FFF_FFFC, 32'h0);
    #1 check("idle_valid", {31'b0, bus.valid}, 32'h0);
    tick;

    // unmapped read: error response only with the macro
    drive(1'b1, 2'b10, 1'b0, 32'h9000_0000, 32'h0);
    #1 check("unmap_valid", {31'b0, bus.valid}, 32'h0);
    tick;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    check("err1_Hresp", {30'b0, bus.Hresp}, ERR_EN ? 32'h1 : 32'h0);
    check("err1_Hready", {31'b0, bus.Hready_err}, ERR_EN ? 32'h0 : 32'h1);
    tick;
    check("err2_Hresp", {30'b0, bus.Hresp}, ERR_EN ? 32'h1 : 32'h0);
    check("err2_Hready", {31'b0, bus.Hready_err}, 32'h1);
    tick;
    check("err_done_Hresp", {30'b0, bus.Hresp}, 32'h0);

    // repeated unmapped transfers re-enter ERR_1 from ERR_2
    drive(1'b1, 2'b11, 1'b0, 32'h8C00_0000, 32'h0);
    #1 check("edge_out_valid", {31'b0, bus.valid}, 32'h0);
    for (int i = 0; i < 3; i++) tick;
    check("rerr_Hready", {31'b0, bus.Hready_err}, ERR_EN ? 32'h0 : 32'h1);
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    tick;
    tick;

    // reset during the error response
    drive(1'b1, 2'b10, 1'b1, 32'hA000_0000, 32'h5555_5555);
    tick;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    Hreset = 1'b1;
    #1;
    check("arst_Hresp", {30'b0, bus.Hresp}, 32'h0);
    check("arst_Hready", {31'b0, bus.Hready_err}, 32'h1);
    check("arst_Haddr1", bus.Haddr1, 32'h0);
    check("arst_Hwdata1", bus.Hwdata1, 32'h0);
    check("arst_Hwrite_reg", {31'b0, bus.Hwrite_reg}, 32'h0);
    #1 Hreset = 1'b0;

    drive(1'b1, 2'b10, 1'b1, 32'h8000_0100, 32'h0);
    tick;
    check("post_rst_Haddr1", bus.Haddr1, 32'h8000_0100);
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h6666_6666);
    tick;
    check("post_rst_Hwdata1", bus.Hwdata1, 32'h6666_6666);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 Hclk  input  1  AHB clock; all state updates on rising edge.
REQ-003 Hreset  input  1  asynchronous active-high reset.
REQ-004 Hwrite  input  1  AHB transfer direction, 1 = write.
REQ-005 Hreadyin  input  1  AHB bus HREADY; 0 = stall.
REQ-006 Htrans  input  2  AHB transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-007 Haddr  input  32  AHB address-phase address.
REQ-008 Hwdata  input  32  AHB data-phase write data.
REQ-009 Prdata  input  32  APB read data returned from peripherals.
REQ-010 valid  output  1  a mapped transfer is being accepted this cycle.
REQ-011 Haddr1, Haddr2  output  32 each  address pipeline stages 1 and 2.
REQ-012 Hwdata1, Hwdata2  output  32 each  write-data pipeline stages 1 and 2.
REQ-013 Hwrite_reg  output  1  Hwrite registered once.
REQ-014 temp_selx  output  3  one-hot peripheral select decoded from Haddr1.
REQ-015 Hrdata  output  32  AHB read data.
REQ-016 Hresp  output  2  AHB response: OKAY 00, ERROR 01.
REQ-017 Hready_err  output  1  error-phase ready contribution; 0 stalls the master.

Function
REQ-018 Address map SHALL be: 0x8000_0000-0x83FF_FFFF -> selx 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; all other addresses unmapped -> 000.
REQ-019 valid SHALL be combinational: Hreadyin AND Htrans in {NONSEQ, SEQ} AND Haddr mapped; BUSY and IDLE SHALL never raise valid.
REQ-020 On each rising edge with Hreadyin=1: Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwrite_reg<=Hwrite.
REQ-021 With Hreadyin=0, all pipeline registers SHALL hold their values.
REQ-022 Pipeline latency SHALL be one cycle to stage 1 and two cycles to stage 2, counted in Hreadyin-high edges.
REQ-023 temp_selx SHALL be a combinational decode of Haddr1.
REQ-024 Hrdata SHALL equal Prdata combinationally, with no added latency.
REQ-025 When AHB_ERR_RESP_EN is not defined, Hresp SHALL be constantly 00, and Hready_err SHALL be constantly 1.

Reset
REQ-026 While Hreset=1, the block SHALL clear Haddr1, Haddr2, Hwdata1, Hwdata2 and Hwrite_reg to 0, regardless of Hclk.
REQ-027 While Hreset=1, the error FSM SHALL be ERR_IDLE, Hresp SHALL be 00 and Hready_err SHALL be 1.
REQ-028 Reset asserted mid error response SHALL abort the response immediately, returning the FSM to ERR_IDLE.
REQ-029 On the first edge after Hreset falls, the block SHALL resume normal operation.

Configuration
REQ-030 Macro AHB_ERR_RESP_EN SHALL compile in the error-response FSM with states ERR_IDLE, ERR_1 and ERR_2.
REQ-031 ERR_IDLE -> ERR_1 SHALL occur on an edge where Hreadyin=1, Htrans is in {NONSEQ, SEQ} and Haddr is unmapped.
REQ-032 In ERR_1 the block SHALL drive Hresp=01 and Hready_err=0, and the FSM SHALL always advance to ERR_2.
REQ-033 In ERR_2 the block SHALL drive Hresp=01 and Hready_err=1.
REQ-034 ERR_2 SHALL go to ERR_1 on a new unmapped active transfer; otherwise it SHALL go to ERR_IDLE.
REQ-035 An unmapped transfer SHALL never raise valid, with or without the macro.
REQ-036 Without AHB_ERR_RESP_EN, unmapped transfers SHALL be silently dropped, always with an OKAY response.

Structure
REQ-037 Package ahb_apb_pkg SHALL hold: Htrans and Hresp encodings, region base/limit constants, selx one-hot codes, and the error-state enum.
REQ-038 Sub-module ahb_addr_decode SHALL provide a combinational address-to-selx decode plus a mapped flag, instantiated twice: once on Haddr for valid/errors, once on Haddr1 for temp_selx.

Verification
REQ-039 Write NONSEQ to 0x8000_0010, data 0xDEAD_BEEF, Hreadyin=1 -> valid=1 in the address cycle; next edge Haddr1=0x8000_0010, temp_selx=001, Hwrite_reg=1; following edge Hwdata1=0xDEAD_BEEF and Haddr2=0x8000_0010.
REQ-040 Back-to-back SEQ writes to 0x8400_0000 and 0x8400_0004 -> Haddr2=0x8400_0000 while Haddr1=0x8400_0004; temp_selx=010.
REQ-041 Hreadyin=0 for 3 cycles mid-burst -> all pipeline outputs frozen and valid=0, then resume with no lost or duplicated stage.
REQ-042 NONSEQ read of 0x9000_0000 with the macro defined -> valid=0; Hresp=01 with Hready_err=0, then Hresp=01 with Hready_err=1, then 00/1. Without the macro -> Hresp stays 00.
REQ-043 Hreset pulsed during ERR_1 -> Hresp=00, Hready_err=1 and all registers 0 before the next Hclk edge.
REQ-044 Read of 0x8800_0020 with Prdata=0x1234_5678 -> Hrdata=0x1234_5678 in the same cycle; temp_selx=100; Htrans=BUSY -> valid=0.
